// File: rtl/sp_types_pkg.sv
// Shared types and widths for the scratchpad memory arbiter.
package sp_types_pkg;

  localparam int unsigned WORD_W       = 16;
  localparam int unsigned BITS_PER_ROW = 32;
  localparam int unsigned ROW_S_W      = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sp_rr_arbiter.sv
// Combinational round-robin selector: first requester after 'last' (mod N).
module sp_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [LW-1:0] idx;

  // Scan requesters starting just after the previous winner, wrapping once.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = LW'((32'(last) + k) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sp_mem_arbiter.sv
// Single-port memory arbiter shared by NUM_SP scratchpad channels.
// One transaction in flight: grant (IDLE) -> memory access (REQ) -> hit (RESP).
module sp_mem_arbiter
  import sp_types_pkg::*;
#(
  parameter int unsigned NUM_SP      = 4,
  parameter int unsigned NUM_ROWS    = 4,
  parameter int unsigned STORE_FIRST = 0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_SP-1:0]                sLoad,
  input  logic [NUM_SP-1:0]                sStore,
  input  logic [NUM_SP*WORD_W-1:0]         load_addr,
  input  logic [NUM_SP*WORD_W-1:0]         store_addr,
  input  logic [NUM_SP*BITS_PER_ROW-1:0]   store_data,
  input  logic [NUM_SP-1:0]                row_clr,
  output logic [NUM_SP*BITS_PER_ROW-1:0]   load_data,
  output logic [NUM_SP-1:0]                sLoad_hit,
  output logic [NUM_SP-1:0]                sStore_hit,
  output logic [NUM_SP*ROW_S_W-1:0]        sLoad_row,
  output logic                             mem_ren,
  output logic                             mem_wen,
  output logic [WORD_W-1:0]                mem_addr,
  output logic [BITS_PER_ROW-1:0]          mem_wdata,
  input  logic [BITS_PER_ROW-1:0]          mem_rdata,
  input  logic                             mem_ready
);

  localparam int unsigned IDX_W = (NUM_SP > 1) ? $clog2(NUM_SP) : 1;

  arb_state_t                       state_q, state_d;
  logic [IDX_W-1:0]                 last_q, last_d;
  logic [IDX_W-1:0]                 chan_q, chan_d;
  logic                             is_store_q, is_store_d;
  logic [WORD_W-1:0]                addr_q, addr_d;
  logic [BITS_PER_ROW-1:0]          wdata_q, wdata_d;
  logic [NUM_SP*BITS_PER_ROW-1:0]   load_data_q, load_data_d;
  logic [NUM_SP*ROW_S_W-1:0]        row_q, row_d;

  logic [NUM_SP-1:0]                gnt;
  logic                             gvalid;
  logic [IDX_W-1:0]                 gidx;
  logic                             load_sel;
  logic [ROW_S_W-1:0]               row_cur;

  sp_rr_arbiter #(.N(NUM_SP)) u_rr (
    .req   (sLoad | sStore),
    .last  (last_q),
    .gnt   (gnt),
    .valid (gvalid)
  );

  // One-hot grant to channel index.
  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NUM_SP; i++) begin
      if (gnt[i]) gidx = IDX_W'(i);
    end
  end

  // Next-state, strobes, hit pulses and row-counter updates.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    chan_d      = chan_q;
    is_store_d  = is_store_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    row_d       = row_q;
    sLoad_hit   = '0;
    sStore_hit  = '0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    load_sel    = 1'b0;
    row_cur     = row_q[chan_q*ROW_S_W +: ROW_S_W];

    case (state_q)
      ARB_IDLE: begin
        if (gvalid) begin
          load_sel   = sLoad[gidx] && !((STORE_FIRST != 0) && sStore[gidx]);
          chan_d     = gidx;
          is_store_d = !load_sel;
          addr_d     = load_sel ? load_addr[gidx*WORD_W +: WORD_W]
                                : store_addr[gidx*WORD_W +: WORD_W];
          wdata_d    = load_sel ? '0 : store_data[gidx*BITS_PER_ROW +: BITS_PER_ROW];
          state_d    = ARB_REQ;
        end
      end
      ARB_REQ: begin
        mem_ren = !is_store_q;
        mem_wen = is_store_q;
        if (mem_ready) begin
          if (!is_store_q) load_data_d[chan_q*BITS_PER_ROW +: BITS_PER_ROW] = mem_rdata;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (is_store_q) begin
          sStore_hit[chan_q] = 1'b1;
        end else begin
          sLoad_hit[chan_q] = 1'b1;
          row_d[chan_q*ROW_S_W +: ROW_S_W] =
            (row_cur == ROW_S_W'(NUM_ROWS - 1)) ? '0 : row_cur + 1'b1;
        end
        last_d  = chan_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    // Clear applied last so it overrides a coincident increment.
    for (int unsigned i = 0; i < NUM_SP; i++) begin
      if (row_clr[i]) row_d[i*ROW_S_W +: ROW_S_W] = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ARB_IDLE;
      last_q      <= IDX_W'(NUM_SP - 1);
      chan_q      <= '0;
      is_store_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      chan_q      <= chan_d;
      is_store_q  <= is_store_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      row_q       <= row_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign load_data = load_data_q;
  assign sLoad_row = row_q;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Self-checking bench for sp_mem_arbiter: transaction-level model plus directed scenarios.
module tb_sp_mem_arbiter;
  import sp_types_pkg::*;

  localparam int unsigned NSP   = 4;
  localparam int unsigned NROWS = 4;
  localparam int unsigned SFIRST = 1;

  logic                        CLK = 1'b0;
  logic                        RST;
  logic [NSP-1:0]              sLoad, sStore, row_clr;
  logic [NSP*WORD_W-1:0]       load_addr, store_addr;
  logic [NSP*BITS_PER_ROW-1:0] store_data, load_data;
  logic [NSP-1:0]              sLoad_hit, sStore_hit;
  logic [NSP*ROW_S_W-1:0]      sLoad_row;
  logic                        mem_ren, mem_wen, mem_ready;
  logic [WORD_W-1:0]           mem_addr;
  logic [BITS_PER_ROW-1:0]     mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NSP-1:0] hold_ld, hold_st;
  int hit_code[$];
  int hit_row[$];

  sp_mem_arbiter #(.NUM_SP(NSP), .NUM_ROWS(NROWS), .STORE_FIRST(SFIRST)) dut (
    .CLK(CLK), .RST(RST), .sLoad(sLoad), .sStore(sStore),
    .load_addr(load_addr), .store_addr(store_addr), .store_data(store_data),
    .row_clr(row_clr), .load_data(load_data), .sLoad_hit(sLoad_hit),
    .sStore_hit(sStore_hit), .sLoad_row(sLoad_row), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rdata_of(input logic [15:0] a);
    return {a ^ 16'hC0DE, a};
  endfunction

  // Memory returns a value derived from the address.
  assign mem_rdata = rdata_of(mem_addr);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_last;
  int          m_rows[NSP];
  logic [31:0] m_lane[NSP];
  bit          m_busy, m_done, m_store;
  int          m_chan;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;

  task automatic model_step();
    bit found;
    int c;
    if (RST) begin
      m_last = NSP - 1; m_busy = 0; m_done = 0; m_store = 0; m_chan = 0;
      m_addr = '0; m_wdata = '0;
      for (int i = 0; i < NSP; i++) begin m_rows[i] = 0; m_lane[i] = '0; end
    end else begin
      if (m_done) begin
        m_done = 0;
        m_last = m_chan;
        if (!m_store) m_rows[m_chan] = (m_rows[m_chan] + 1) % NROWS;
      end else if (m_busy) begin
        if (mem_ready) begin
          m_busy = 0; m_done = 1;
          if (!m_store) m_lane[m_chan] = rdata_of(m_addr);
        end
      end else begin
        found = 0;
        for (int k = 1; k <= NSP; k++) begin
          c = (m_last + k) % NSP;
          if (!found && (sLoad[c] || sStore[c])) begin
            found   = 1;
            m_chan  = c;
            m_store = sStore[c] && (SFIRST != 0 || !sLoad[c]);
            m_addr  = m_store ? store_addr[c*WORD_W +: WORD_W] : load_addr[c*WORD_W +: WORD_W];
            m_wdata = m_store ? store_data[c*32 +: 32] : 32'h0;
            m_busy  = 1;
          end
        end
      end
      for (int i = 0; i < NSP; i++) if (row_clr[i]) m_rows[i] = 0;
    end
  endtask

  // Advance the model on each edge, then compare all outputs shortly after.
  always @(posedge CLK) begin
    logic [NSP-1:0] e_lhit, e_shit;
    logic [NSP*ROW_S_W-1:0] e_rows;
    logic [NSP*32-1:0] e_ld;
    model_step();
    #1;
    e_lhit = '0; e_shit = '0;
    if (m_done && !m_store) e_lhit[m_chan] = 1'b1;
    if (m_done &&  m_store) e_shit[m_chan] = 1'b1;
    for (int i = 0; i < NSP; i++) begin
      e_rows[i*ROW_S_W +: ROW_S_W] = ROW_S_W'(m_rows[i]);
      e_ld[i*32 +: 32] = m_lane[i];
    end
    check("mem_ren", mem_ren, m_busy && !m_store);
    check("mem_wen", mem_wen, m_busy && m_store);
    check("strobe_excl", mem_ren & mem_wen, 1'b0);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("sLoad_hit", sLoad_hit, e_lhit);
    check("sStore_hit", sStore_hit, e_shit);
    check("sLoad_row", sLoad_row, e_rows);
    check("load_data", load_data, e_ld);
    for (int i = 0; i < NSP; i++) begin
      if (sLoad_hit[i])  begin hit_code.push_back(i);        hit_row.push_back(int'(sLoad_row[i*ROW_S_W +: ROW_S_W])); end
      if (sStore_hit[i]) begin hit_code.push_back(i + 'h10); hit_row.push_back(-1); end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge CLK);
    for (int i = 0; i < NSP; i++) begin
      if (sLoad_hit[i]  && !hold_ld[i]) sLoad[i]  = 1'b0;
      if (sStore_hit[i] && !hold_st[i]) sStore[i] = 1'b0;
    end
  endtask

  task automatic wait_hits(input int n, input int budget);
    int b;
    b = budget;
    while (hit_code.size() < n && b > 0) begin tick(); b--; end
    if (hit_code.size() < n) check("hit_timeout", hit_code.size(), n);
  endtask

  task automatic do_reset();
    sLoad = '0; sStore = '0; row_clr = '0; hold_ld = '0; hold_st = '0; mem_ready = 1'b1;
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    hit_code.delete(); hit_row.delete();
  endtask

  initial begin
    RST = 1'b1; sLoad = '0; sStore = '0; row_clr = '0; mem_ready = 1'b1;
    hold_ld = '0; hold_st = '0;
    load_addr  = {16'h0340, 16'h0230, 16'h0120, 16'h0010};
    store_addr = {16'h8300, 16'h8200, 16'h8100, 16'h8000};
    store_data = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    tick(); tick();
    check("rst_ren", mem_ren, 1'b0);
    check("rst_rows", sLoad_row, '0);
    check("rst_ldata", load_data, '0);
    check("rst_addr", mem_addr, '0);
    RST = 1'b0;
    tick();

    // Single load on channel 0: strobe one cycle after grant, hit on cycle 3.
    sLoad = 4'b0001;
    @(posedge CLK); #2;
    check("t1_ren", mem_ren, 1'b1);
    check("t1_addr", mem_addr, 16'h0010);
    @(posedge CLK); #2;
    check("t1_hit", sLoad_hit, 4'b0001);
    check("t1_row", sLoad_row[2:0], 3'd0);
    check("t1_data", load_data[31:0], 32'hC0CE_0010);
    tick(); tick(); tick();

    // All four channels held: round-robin order 0,1,2,3,0.
    do_reset();
    hold_ld = 4'b1111; sLoad = 4'b1111;
    wait_hits(5, 60);
    sLoad = '0; hold_ld = '0;
    if (hit_code.size() >= 5) begin
      check("rr_0", hit_code[0], 0); check("rr_1", hit_code[1], 1);
      check("rr_2", hit_code[2], 2); check("rr_3", hit_code[3], 3);
      check("rr_4", hit_code[4], 0);
    end
    tick(); tick();

    // Row counter wrap on channel 2.
    do_reset();
    hold_ld = 4'b0100; sLoad = 4'b0100;
    wait_hits(5, 60);
    sLoad = '0; hold_ld = '0;
    if (hit_row.size() >= 5) begin
      check("row_0", hit_row[0], 0); check("row_1", hit_row[1], 1);
      check("row_2", hit_row[2], 2); check("row_3", hit_row[3], 3);
      check("row_4", hit_row[4], 0);
    end
    tick(); tick();

    // Channel 1 load+store with store priority: store hit first.
    do_reset();
    sLoad = 4'b0010; sStore = 4'b0010;
    wait_hits(2, 40);
    if (hit_code.size() >= 2) begin
      check("ls_first", hit_code[0], 'h11);
      check("ls_second", hit_code[1], 'h01);
    end
    tick(); tick();

    // Stalled memory aborted by reset: no hit, strobes drop.
    do_reset();
    mem_ready = 1'b0; sLoad = 4'b0010;
    repeat (10) tick();
    check("stall_ren", mem_ren, 1'b1);
    check("stall_nohit", hit_code.size(), 0);
    RST = 1'b1;
    @(posedge CLK); #2;
    check("abort_ren", mem_ren, 1'b0);
    check("abort_wen", mem_wen, 1'b0);
    check("abort_hit", sLoad_hit | sStore_hit, 4'b0000);
    tick();
    RST = 1'b0; sLoad = '0; mem_ready = 1'b1;
    tick(); tick();
    check("abort_idle", mem_ren | mem_wen, 1'b0);
    check("abort_nohit", hit_code.size(), 0);

    // Clear coinciding with the row-2 hit on channel 3 wins.
    do_reset();
    hold_ld = 4'b1000; sLoad = 4'b1000;
    begin
      int b;
      bit seen;
      b = 60; seen = 0;
      while (!seen && b > 0) begin
        tick(); b--;
        if (sLoad_hit[3] && sLoad_row[11:9] == 3'd2) seen = 1;
      end
      check("clr_seen", seen, 1'b1);
    end
    row_clr = 4'b1000;
    hit_code.delete(); hit_row.delete();
    tick();
    row_clr = '0;
    wait_hits(1, 20);
    sLoad = '0; hold_ld = '0;
    if (hit_row.size() >= 1) begin
      check("clr_chan", hit_code[0], 3);
      check("clr_row", hit_row[0], 0);
    end
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
